// File: rtl/occ_pkg.sv
// rtl/occ_pkg.sv - shared constants, FSM states and trailer helper for the occupancy stream writer
package occ_pkg;

    localparam int          OCC_WORD_W        = 64;
    localparam logic [15:0] OCC_TRAILER_MAGIC = 16'h0CC0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STREAM  = 2'd1,
        ST_TRAILER = 2'd2,
        ST_DONE    = 2'd3
    } occ_state_t;

    // Trailer beat: magic, two reserved halfwords, beat count including the trailer itself.
    function automatic logic [OCC_WORD_W-1:0] occ_trailer_word(input logic [31:0] count);
        return {OCC_TRAILER_MAGIC, 16'h0000, 16'h0000, count[15:0]};
    endfunction

endpackage

// File: rtl/occ_sync_fifo.sv
// rtl/occ_sync_fifo.sv - single-clock first-word-fall-through FIFO with wrap-bit pointers
module occ_sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // A write into a full FIFO is legal when the head leaves in the same cycle.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/occ_code_stream_writer.sv
// rtl/occ_code_stream_writer.sv - buffers BFS occupancy words and streams them with tlast/done
// Optional trailer beat carrying the beat count is enabled by defining OCC_TRAILER_EN.
module occ_code_stream_writer
    import occ_pkg::*;
#(
    parameter int DATA_W     = OCC_WORD_W,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_W-1:0]             i_occ_code,
    input  logic                          i_send,
    input  logic                          i_finish,
    output logic [DATA_W-1:0]             o_m_tdata,
    output logic                          o_m_tvalid,
    input  logic                          i_m_tready,
    output logic                          o_m_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [CNT_W-1:0]              o_words_sent,
    output logic                          o_overflow,
    output logic                          o_done
);

    occ_state_t         state;
    logic               fin_q;
    logic               fin_rise;
    logic               fin_fall;
    logic               last_pend;
    logic               accepting;
    logic               push_req;
    logic               push_last;
    logic               push_ok;
    logic               drop;
    logic               pop;
    logic               hs;
    logic               hs_last;
    logic               f_empty;
    logic               f_full;
    logic [DATA_W:0]    f_rd;
    logic [DATA_W:0]    push_entry;
    logic [CNT_W-1:0]   ws_next;

    assign fin_rise  = i_finish & ~fin_q;
    assign fin_fall  = ~i_finish & fin_q;
    assign accepting = (state == ST_IDLE) || (state == ST_STREAM);
    assign push_last = fin_rise;

`ifdef OCC_TRAILER_EN
    // The trailer closes the traversal, so a bare finish edge needs no flush entry.
    assign push_req = accepting & i_send;
`else
    assign push_req = accepting & (i_send | fin_rise);
`endif

    assign push_entry = {push_last, (i_send ? i_occ_code : {DATA_W{1'b0}})};
    assign pop        = !f_empty && i_m_tready;
    assign push_ok    = push_req && (!f_full || pop);
    assign drop       = push_req && !push_ok;
    assign hs         = o_m_tvalid && i_m_tready;
    assign hs_last    = pop && f_rd[DATA_W];
    assign ws_next    = o_words_sent + CNT_W'(hs);

    occ_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .wr_en   (push_ok),
        .wr_data (push_entry),
        .rd_en   (pop),
        .rd_data (f_rd),
        .empty   (f_empty),
        .full    (f_full),
        .level   (o_fifo_level)
    );

`ifdef OCC_TRAILER_EN
    logic [DATA_W-1:0] trailer_q;

    assign o_m_tvalid = (state == ST_TRAILER) || !f_empty;
    assign o_m_tdata  = (state == ST_TRAILER) ? trailer_q
                      : (f_empty ? {DATA_W{1'b0}} : f_rd[DATA_W-1:0]);
    assign o_m_tlast  = (state == ST_TRAILER);
`else
    assign o_m_tvalid = !f_empty;
    assign o_m_tdata  = f_empty ? {DATA_W{1'b0}} : f_rd[DATA_W-1:0];
    assign o_m_tlast  = !f_empty && f_rd[DATA_W];
`endif

    assign o_done = (state == ST_DONE);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= ST_IDLE;
            fin_q        <= 1'b0;
            last_pend    <= 1'b0;
            o_overflow   <= 1'b0;
            o_words_sent <= '0;
`ifdef OCC_TRAILER_EN
            trailer_q    <= '0;
`endif
        end else begin
            fin_q <= i_finish;
            if (hs) o_words_sent <= ws_next;
            if (drop) o_overflow <= 1'b1;
            // A lost last entry still has to close the traversal once the FIFO drains.
            if (drop && push_last) last_pend <= 1'b1;
`ifdef OCC_TRAILER_EN
            if (accepting && fin_rise && !i_send) last_pend <= 1'b1;
`endif
            case (state)
                ST_IDLE: begin
                    if (push_ok || last_pend) state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (hs_last || (last_pend && f_empty)) begin
`ifdef OCC_TRAILER_EN
                        state     <= ST_TRAILER;
                        trailer_q <= DATA_W'(occ_trailer_word(32'(ws_next) + 32'd1));
`else
                        state     <= ST_DONE;
`endif
                    end
                end
                ST_TRAILER: begin
                    if (hs) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (fin_fall) begin
                        state        <= ST_IDLE;
                        o_words_sent <= '0;
                        last_pend    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_occ_code_stream_writer.sv
// tb/tb_occ_code_stream_writer.sv - directed self-checking bench for occ_code_stream_writer
module tb_occ_code_stream_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] occ = '0;
    logic        send = 1'b0;
    logic        fin = 1'b0;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        tlast;
    logic [4:0]  level;
    logic [15:0] wsent;
    logic        ovf;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        send;
        logic [63:0] occ;
        logic        fin;
        logic        rdy;
        logic        e_valid;
        logic [63:0] e_data;
        logic        e_last;
        int          e_level;
        int          e_ws;
        logic        e_done;
    } vec_t;

    vec_t tbl[$];

    localparam logic [63:0] WA = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] WB = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] WC = 64'h1111_2222_3333_4444;
    localparam logic [63:0] WD = 64'hDDDD_0000_DDDD_0001;
    localparam logic [63:0] WE = 64'hEEEE_5555_EEEE_6666;

    always #5 clk = ~clk;

    occ_code_stream_writer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_occ_code   (occ),
        .i_send       (send),
        .i_finish     (fin),
        .o_m_tdata    (tdata),
        .o_m_tvalid   (tvalid),
        .i_m_tready   (tready),
        .o_m_tlast    (tlast),
        .o_fifo_level (level),
        .o_words_sent (wsent),
        .o_overflow   (ovf),
        .o_done       (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; send = 1'b0; fin = 1'b0; tready = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic finish_traversal(input int exp_ws, input string tag);
        bit ok = 1'b0;
        fin = 1'b1;
        tready = 1'b1;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
            else next_cycle();
        end
        chk({tag, " done_reached"}, 64'(ok), 64'd1);
        chk({tag, " words_sent"}, 64'(wsent), 64'(exp_ws));
        next_cycle();
        fin = 1'b0;
        next_cycle();
        @(negedge clk);
        chk({tag, " rearm_done"}, 64'(done), 64'd0);
        chk({tag, " rearm_ws"}, 64'(wsent), 64'd0);
        next_cycle();
    endtask

    initial begin
        logic [63:0] q[$];
        logic        prev_stall;
        logic [63:0] prev_data;
`ifdef OCC_TRAILER_EN
        logic [63:0] tr3 = {16'h0CC0, 32'h0, 16'h0003};
        logic [63:0] tr2 = {16'h0CC0, 32'h0, 16'h0002};
        tbl.push_back('{1'b1, WA,    1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 0, 0, 1'b0});
        tbl.push_back('{1'b1, WB,    1'b0, 1'b1, 1'b1, WA,    1'b0, 1, 0, 1'b0});
        tbl.push_back('{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, WB,    1'b0, 1, 1, 1'b0});
        tbl.push_back('{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 0, 2, 1'b0});
        tbl.push_back('{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, tr3,   1'b1, 0, 2, 1'b0});
        tbl.push_back('{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 0, 3, 1'b1});
        tbl.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 0, 3, 1'b1});
        tbl.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 0, 0, 1'b0});
`else
        tbl.push_back('{1'b1, WA,    1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 0, 0, 1'b0});
        tbl.push_back('{1'b1, WB,    1'b0, 1'b1, 1'b1, WA,    1'b0, 1, 0, 1'b0});
        tbl.push_back('{1'b1, WC,    1'b0, 1'b1, 1'b1, WB,    1'b0, 1, 1, 1'b0});
        tbl.push_back('{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, WC,    1'b0, 1, 2, 1'b0});
        tbl.push_back('{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h0, 1'b1, 1, 3, 1'b0});
        tbl.push_back('{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 0, 4, 1'b1});
        tbl.push_back('{1'b1, WE,    1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 0, 4, 1'b1});
        tbl.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 0, 4, 1'b1});
        tbl.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 0, 0, 1'b0});
`endif

        // Reset values while held in reset
        #2;
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        do_reset();

        // Basic traversal, table driven
        for (int i = 0; i < tbl.size(); i++) begin
            send = tbl[i].send; occ = tbl[i].occ; fin = tbl[i].fin; tready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("t1[%0d] tvalid", i), 64'(tvalid), 64'(tbl[i].e_valid));
            chk($sformatf("t1[%0d] tdata", i), tdata, tbl[i].e_data);
            chk($sformatf("t1[%0d] tlast", i), 64'(tlast), 64'(tbl[i].e_last));
            chk($sformatf("t1[%0d] level", i), 64'(level), 64'(tbl[i].e_level));
            chk($sformatf("t1[%0d] wsent", i), 64'(wsent), 64'(tbl[i].e_ws));
            chk($sformatf("t1[%0d] done", i), 64'(done), 64'(tbl[i].e_done));
            next_cycle();
        end
        send = 1'b0; fin = 1'b0;

        // Send coinciding with finish edge
        send = 1'b1; occ = WD; fin = 1'b1; tready = 1'b1;
        next_cycle();
        send = 1'b0;
        @(negedge clk);
        chk("t2 tvalid", 64'(tvalid), 64'd1);
        chk("t2 tdata", tdata, WD);
`ifdef OCC_TRAILER_EN
        chk("t2 tlast_data", 64'(tlast), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("t2 trailer", tdata, tr2);
        chk("t2 tlast_trailer", 64'(tlast), 64'd1);
        next_cycle();
        @(negedge clk);
        chk("t2 done", 64'(done), 64'd1);
        chk("t2 wsent", 64'(wsent), 64'd2);
`else
        chk("t2 tlast", 64'(tlast), 64'd1);
        next_cycle();
        @(negedge clk);
        chk("t2 done", 64'(done), 64'd1);
        chk("t2 wsent", 64'(wsent), 64'd1);
        chk("t2 tvalid_after", 64'(tvalid), 64'd0);
`endif
        next_cycle();
        fin = 1'b0;
        next_cycle();

        // Overflow: 17 words into a 16-deep FIFO while stalled
        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send = 1'b1; occ = 64'h100 + 64'(i);
            next_cycle();
        end
        send = 1'b0;
        @(negedge clk);
        chk("t3 level_full", 64'(level), 64'd16);
        chk("t3 overflow", 64'(ovf), 64'd1);
        next_cycle();
        tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("t3 beat%0d", i), tvalid ? tdata : 64'hX, 64'h100 + 64'(i));
            next_cycle();
        end
        @(negedge clk);
        chk("t3 level_empty", 64'(level), 64'd0);
        next_cycle();
        finish_traversal(17, "t3");

        // Full FIFO with simultaneous push and pop, then random stalls
        do_reset();
        @(negedge clk);
        chk("t4 ovf_cleared", 64'(ovf), 64'd0);
        next_cycle();
        for (int i = 0; i < 16; i++) begin
            send = 1'b1; occ = 64'h200 + 64'(i);
            next_cycle();
        end
        send = 1'b0;
        @(negedge clk);
        chk("t4 level_full", 64'(level), 64'd16);
        next_cycle();
        send = 1'b1; occ = 64'h210; tready = 1'b1;
        @(negedge clk);
        chk("t4 head_pre", tdata, 64'h200);
        next_cycle();
        send = 1'b0; tready = 1'b0;
        @(negedge clk);
        chk("t4 level_same", 64'(level), 64'd16);
        chk("t4 no_overflow", 64'(ovf), 64'd0);
        for (int i = 1; i <= 16; i++) q.push_back(64'h200 + 64'(i));
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int k = 0; k < 300 && q.size() > 0; k++) begin
            next_cycle();
            tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall) chk("t4 stable", tdata, prev_data);
            if (tvalid) chk("t4 order", tdata, q[0]);
            if (tvalid && tready) void'(q.pop_front());
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
        end
        chk("t4 drained", 64'(q.size()), 64'd0);
        chk("t4 ovf_end", 64'(ovf), 64'd0);
        next_cycle();
        finish_traversal(18, "t4");

        // Asynchronous reset mid-stream
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send = 1'b1; occ = 64'h300 + 64'(i);
            next_cycle();
        end
        send = 1'b0;
        @(negedge clk);
        chk("t5 level5", 64'(level), 64'd5);
        #2 rst = 1'b0;
        #1;
        chk("t5 tvalid", 64'(tvalid), 64'd0);
        chk("t5 level", 64'(level), 64'd0);
        chk("t5 done", 64'(done), 64'd0);
        chk("t5 tdata", tdata, 64'd0);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        send = 1'b1; occ = WE;
        next_cycle();
        send = 1'b0;
        @(negedge clk);
        chk("t5 new_tvalid", 64'(tvalid), 64'd1);
        chk("t5 new_tdata", tdata, WE);
        chk("t5 new_level", 64'(level), 64'd1);
        next_cycle();
        finish_traversal(2, "t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
